alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Reservation station directly upstream of the combinational ALU in the Tomasulo core.
- Buffers decoded ALU/branch/jump ops from issue and snoops the CDBs for missing operands.
- Each cycle it dispatches at most one ready entry to the ALU through registered outputs.

Parameters:
RS_SIZE, 16, number of entries (power of two, ≥2)
ROB_W, 4, width of ROB entry tags

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
clear  in  1  mispredict flush
issue_sgn  in  1  issue valid
issue_opcode  in  6  internal opcode (ALU encoding)
issue_vj  in  32  rs1 value when ready
issue_qj  in  ROB_W  rs1 producer tag
issue_qj_busy  in  1  1 = rs1 waiting on issue_qj
issue_vk  in  32  rs2 value when ready
issue_qk  in  ROB_W  rs2 producer tag
issue_qk_busy  in  1  1 = rs2 waiting on issue_qk
issue_imm  in  32  immediate
issue_pc  in  32  instruction pc
issue_rob  in  ROB_W  destination ROB entry
rs_full  out  1  no free entry
alu_cdb_sgn  in  1  ALU broadcast valid
alu_cdb_rob  in  ROB_W  ALU broadcast tag
alu_cdb_result  in  32  ALU broadcast value
lsb_cdb_sgn  in  1  load/store broadcast valid
lsb_cdb_rob  in  ROB_W  load/store broadcast tag
lsb_cdb_result  in  32  load/store broadcast value
alu_sgn  out  1  dispatch valid to ALU
alu_opcode  out  6  dispatched opcode
alu_lhs  out  32  dispatched Vj
alu_rhs  out  32  dispatched Vk
alu_imm  out  32  dispatched imm
alu_pc  out  32  dispatched pc
alu_rob  out  ROB_W  dispatched ROB entry

Behaviour:
- Priority per rising edge: rst > !rdy (hold everything) > clear > normal.
- rst: all entries invalid; all outputs 0; rs_full 0.
- clear (with rdy): all entries invalid; alu_sgn and all alu_* outputs 0. Same-cycle issue and dispatch are discarded.
- Entry state: busy, opcode, Vj/Qj/Qj_busy, Vk/Qk/Qk_busy, imm, pc, rob.
- rs_full is combinational from registered state. It is 1 iff all RS_SIZE entries are busy; a same-cycle dispatch does not count as a free slot.
- Issue:
  - If issue_sgn && !rs_full, write the lowest-index non-busy entry at the edge.
  - If issue_sgn && rs_full, the issue is ignored (issuer must stall).
- Issue-time forwarding: an operand with *_busy=1 whose tag matches a CDB broadcast valid in the same cycle is stored with the broadcast value and busy=0.
- Wakeup: each busy entry compares Qj and Qk against both CDBs every cycle. On a match it captures the value and clears the busy bit. Both CDBs matching the same tag cannot occur; if it does, the ALU CDB wins.
- Dispatch select:
  - Pick the lowest-index entry that is busy with Qj_busy=0 and Qk_busy=0, using registered state at the start of the cycle.
  - At the edge: load alu_* from that entry, set alu_sgn=1, free the entry.
  - If no entry is ready, alu_sgn=0 and the other alu_* outputs hold their last values.
- Latency:
  - An op issued with both operands ready at edge N dispatches at edge N+1 at the earliest.
  - An operand woken at edge M makes its entry eligible for dispatch at edge M+1.
- A slot freed by dispatch at edge N is reusable by an issue arriving in the cycle after edge N.
- Issue and dispatch in the same cycle are independent; the issue targets a slot that was already free.
- At most one dispatch per cycle; the remaining ready entries wait, with lowest index first.
- While rdy=0, outputs hold, including alu_sgn. Downstream logic is also rdy-gated.
- Widths: tag compares are ROB_W bits exact; no arithmetic is performed here.

Test Plan:
- Reset, then issue ADDI with vj=5, imm=3, rob=2, both operands ready → alu_sgn=1 one edge later with lhs=5, imm=3, rob=2; the next cycle alu_sgn=0.
- Issue ADD with qj=7 busy; broadcast alu_cdb rob=7 result=0x10 two cycles later → dispatch the edge after the broadcast with lhs=0x10.
- Issue with qk=3 busy while lsb_cdb_sgn=1, rob=3, result=0xAB in the same cycle → entry captured ready; dispatch at the next edge with rhs=0xAB.
- Fill 16 entries, all waiting → rs_full=1 and a 17th issue is dropped. Wake entries 4 and 9 in the same cycle → entry 4 dispatches first, entry 9 at the following edge; rs_full falls after the first dispatch.
- With 5 entries queued and one dispatch pending, assert clear → at the next edge all entries are invalid, alu_sgn=0, and subsequent wakeups of old tags cause no dispatch.
- Hold rdy=0 for 3 cycles with a ready entry and a CDB broadcast present → no state change; dispatch occurs one edge after rdy returns to 1.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// Issue, CDB snoop and ALU dispatch signals of the ALU reservation station.
// master = issue/CDB side that drives the station, slave = the station itself.
interface alu_reservation_station_if #(
    parameter int ROB_W = 4
);
    logic             issue_sgn;
    logic [5:0]       issue_opcode;
    logic [31:0]      issue_vj;
    logic [ROB_W-1:0] issue_qj;
    logic             issue_qj_busy;
    logic [31:0]      issue_vk;
    logic [ROB_W-1:0] issue_qk;
    logic             issue_qk_busy;
    logic [31:0]      issue_imm;
    logic [31:0]      issue_pc;
    logic [ROB_W-1:0] issue_rob;
    logic             rs_full;

    logic             alu_cdb_sgn;
    logic [ROB_W-1:0] alu_cdb_rob;
    logic [31:0]      alu_cdb_result;
    logic             lsb_cdb_sgn;
    logic [ROB_W-1:0] lsb_cdb_rob;
    logic [31:0]      lsb_cdb_result;

    logic             alu_sgn;
    logic [5:0]       alu_opcode;
    logic [31:0]      alu_lhs;
    logic [31:0]      alu_rhs;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_pc;
    logic [ROB_W-1:0] alu_rob;

    modport master (
        output issue_sgn, issue_opcode, issue_vj, issue_qj, issue_qj_busy,
               issue_vk, issue_qk, issue_qk_busy, issue_imm, issue_pc, issue_rob,
               alu_cdb_sgn, alu_cdb_rob, alu_cdb_result,
               lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_result,
        input  rs_full, alu_sgn, alu_opcode, alu_lhs, alu_rhs, alu_imm, alu_pc, alu_rob
    );

    modport slave (
        input  issue_sgn, issue_opcode, issue_vj, issue_qj, issue_qj_busy,
               issue_vk, issue_qk, issue_qk_busy, issue_imm, issue_pc, issue_rob,
               alu_cdb_sgn, alu_cdb_rob, alu_cdb_result,
               lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_result,
        output rs_full, alu_sgn, alu_opcode, alu_lhs, alu_rhs, alu_imm, alu_pc, alu_rob
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Reservation station in front of the ALU: buffers issued ops, snoops both CDBs
// for missing operands and dispatches the lowest-index ready entry each cycle.
module alu_reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic clear,
    alu_reservation_station_if.slave rs
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [5:0]         opcode_arr [RS_SIZE];
    logic [31:0]        vj_arr     [RS_SIZE];
    logic [31:0]        vk_arr     [RS_SIZE];
    logic [31:0]        imm_arr    [RS_SIZE];
    logic [31:0]        pc_arr     [RS_SIZE];
    logic [ROB_W-1:0]   rob_arr    [RS_SIZE];

    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] disp_idx;
    logic             has_disp;
    logic             rs_full_w;
    logic             issue_fire;

    logic             alu_sgn_reg;
    logic [5:0]       alu_opcode_reg;
    logic [31:0]      alu_lhs_reg;
    logic [31:0]      alu_rhs_reg;
    logic [31:0]      alu_imm_reg;
    logic [31:0]      alu_pc_reg;
    logic [ROB_W-1:0] alu_rob_reg;

    // Resolve one operand against both CDBs; the ALU CDB wins a tag collision.
    // Result is {still_busy, value}.
    function automatic logic [32:0] snoop(
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      val,
        input logic             a_sgn,
        input logic [ROB_W-1:0] a_rob,
        input logic [31:0]      a_res,
        input logic             l_sgn,
        input logic [ROB_W-1:0] l_rob,
        input logic [31:0]      l_res
    );
        logic [32:0] r;
        r = {busy, val};
        if (busy && a_sgn && (a_rob == tag)) begin
            r = {1'b0, a_res};
        end else if (busy && l_sgn && (l_rob == tag)) begin
            r = {1'b0, l_res};
        end
        return r;
    endfunction

    assign rs_full_w  = &busy_vec;
    assign issue_fire = rs.issue_sgn && !rs_full_w;
    assign has_disp   = |ready_vec;

    always_comb begin
        free_idx = '0;
        disp_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_idx = IDX_W'(i);
            end
            if (ready_vec[i]) begin
                disp_idx = IDX_W'(i);
            end
        end
    end

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        logic             busy_reg;
        logic [5:0]       opcode_reg;
        logic [31:0]      vj_reg;
        logic [ROB_W-1:0] qj_reg;
        logic             qj_busy_reg;
        logic [31:0]      vk_reg;
        logic [ROB_W-1:0] qk_reg;
        logic             qk_busy_reg;
        logic [31:0]      imm_reg;
        logic [31:0]      pc_reg;
        logic [ROB_W-1:0] rob_reg;

        logic             issue_here;
        logic             disp_here;
        logic [32:0]      j_next;
        logic [32:0]      k_next;

        assign issue_here = issue_fire && (free_idx == IDX_W'(gi));
        assign disp_here  = has_disp && (disp_idx == IDX_W'(gi));

        // A freshly issued operand goes through the same snoop as a waiting one,
        // which gives issue-time forwarding for free.
        always_comb begin
            if (issue_here) begin
                j_next = snoop(rs.issue_qj_busy, rs.issue_qj, rs.issue_vj,
                               rs.alu_cdb_sgn, rs.alu_cdb_rob, rs.alu_cdb_result,
                               rs.lsb_cdb_sgn, rs.lsb_cdb_rob, rs.lsb_cdb_result);
                k_next = snoop(rs.issue_qk_busy, rs.issue_qk, rs.issue_vk,
                               rs.alu_cdb_sgn, rs.alu_cdb_rob, rs.alu_cdb_result,
                               rs.lsb_cdb_sgn, rs.lsb_cdb_rob, rs.lsb_cdb_result);
            end else begin
                j_next = snoop(qj_busy_reg, qj_reg, vj_reg,
                               rs.alu_cdb_sgn, rs.alu_cdb_rob, rs.alu_cdb_result,
                               rs.lsb_cdb_sgn, rs.lsb_cdb_rob, rs.lsb_cdb_result);
                k_next = snoop(qk_busy_reg, qk_reg, vk_reg,
                               rs.alu_cdb_sgn, rs.alu_cdb_rob, rs.alu_cdb_result,
                               rs.lsb_cdb_sgn, rs.lsb_cdb_rob, rs.lsb_cdb_result);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                busy_reg    <= 1'b0;
                qj_busy_reg <= 1'b0;
                qk_busy_reg <= 1'b0;
            end else if (rdy) begin
                if (clear) begin
                    busy_reg <= 1'b0;
                end else begin
                    if (issue_here) begin
                        busy_reg   <= 1'b1;
                        opcode_reg <= rs.issue_opcode;
                        qj_reg     <= rs.issue_qj;
                        qk_reg     <= rs.issue_qk;
                        imm_reg    <= rs.issue_imm;
                        pc_reg     <= rs.issue_pc;
                        rob_reg    <= rs.issue_rob;
                    end else if (disp_here) begin
                        busy_reg <= 1'b0;
                    end
                    if (issue_here || busy_reg) begin
                        qj_busy_reg <= j_next[32];
                        vj_reg      <= j_next[31:0];
                        qk_busy_reg <= k_next[32];
                        vk_reg      <= k_next[31:0];
                    end
                end
            end
        end

        assign busy_vec[gi]   = busy_reg;
        assign ready_vec[gi]  = busy_reg && !qj_busy_reg && !qk_busy_reg;
        assign opcode_arr[gi] = opcode_reg;
        assign vj_arr[gi]     = vj_reg;
        assign vk_arr[gi]     = vk_reg;
        assign imm_arr[gi]    = imm_reg;
        assign pc_arr[gi]     = pc_reg;
        assign rob_arr[gi]    = rob_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_sgn_reg    <= 1'b0;
            alu_opcode_reg <= '0;
            alu_lhs_reg    <= '0;
            alu_rhs_reg    <= '0;
            alu_imm_reg    <= '0;
            alu_pc_reg     <= '0;
            alu_rob_reg    <= '0;
        end else if (rdy) begin
            if (clear) begin
                alu_sgn_reg    <= 1'b0;
                alu_opcode_reg <= '0;
                alu_lhs_reg    <= '0;
                alu_rhs_reg    <= '0;
                alu_imm_reg    <= '0;
                alu_pc_reg     <= '0;
                alu_rob_reg    <= '0;
            end else if (has_disp) begin
                alu_sgn_reg    <= 1'b1;
                alu_opcode_reg <= opcode_arr[disp_idx];
                alu_lhs_reg    <= vj_arr[disp_idx];
                alu_rhs_reg    <= vk_arr[disp_idx];
                alu_imm_reg    <= imm_arr[disp_idx];
                alu_pc_reg     <= pc_arr[disp_idx];
                alu_rob_reg    <= rob_arr[disp_idx];
            end else begin
                alu_sgn_reg <= 1'b0;
            end
        end
    end

    assign rs.rs_full    = rs_full_w;
    assign rs.alu_sgn    = alu_sgn_reg;
    assign rs.alu_opcode = alu_opcode_reg;
    assign rs.alu_lhs    = alu_lhs_reg;
    assign rs.alu_rhs    = alu_rhs_reg;
    assign rs.alu_imm    = alu_imm_reg;
    assign rs.alu_pc     = alu_pc_reg;
    assign rs.alu_rob    = alu_rob_reg;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: a slot-array model predicts each
// dispatch (edge number and payload); a monitor checks every dispatch the DUT makes.
module tb_alu_reservation_station;
    logic clk;
    logic rst;
    logic rdy;
    logic clear;

    alu_reservation_station_if #(.ROB_W(4)) ifc ();

    alu_reservation_station #(.RS_SIZE(16), .ROB_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .rs    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [5:0]  op;
        logic [31:0] vj;
        logic [3:0]  qj;
        bit          qjb;
        logic [31:0] vk;
        logic [3:0]  qk;
        bit          qkb;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } ent_t;

    typedef struct {
        int          edge_no;
        logic [5:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } exp_t;

    ent_t m[16];
    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic bit m_full();
        for (int i = 0; i < 16; i++) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void resolve(input bit b, input logic [3:0] q, input logic [31:0] v,
                                    output bit nb, output logic [31:0] nv);
        nb = b;
        nv = v;
        if (b && ifc.alu_cdb_sgn && ifc.alu_cdb_rob == q) begin
            nb = 1'b0; nv = ifc.alu_cdb_result;
        end else if (b && ifc.lsb_cdb_sgn && ifc.lsb_cdb_rob == q) begin
            nb = 1'b0; nv = ifc.lsb_cdb_result;
        end
    endfunction

    // Effect of the coming rising edge on the model, given the inputs now driven.
    task automatic model_edge();
        int   f;
        int   d;
        bit   full;
        ent_t e;
        exp_t x;
        if (rst) begin
            foreach (m[i]) m[i].v = 1'b0;
            exp_q.delete();
            return;
        end
        if (!rdy) return;
        if (clear) begin
            foreach (m[i]) m[i].v = 1'b0;
            return;
        end
        full = m_full();
        f = -1;
        d = -1;
        for (int i = 0; i < 16; i++) begin
            if (!m[i].v && f < 0) f = i;
            if (m[i].v && !m[i].qjb && !m[i].qkb && d < 0) d = i;
        end
        if (d >= 0) begin
            x.edge_no = edge_cnt + 1;
            x.op = m[d].op; x.lhs = m[d].vj; x.rhs = m[d].vk;
            x.imm = m[d].imm; x.pc = m[d].pc; x.rob = m[d].rob;
            exp_q.push_back(x);
            m[d].v = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].v) begin
                resolve(m[i].qjb, m[i].qj, m[i].vj, m[i].qjb, m[i].vj);
                resolve(m[i].qkb, m[i].qk, m[i].vk, m[i].qkb, m[i].vk);
            end
        end
        if (ifc.issue_sgn && !full) begin
            e.v = 1'b1; e.op = ifc.issue_opcode; e.qj = ifc.issue_qj; e.qk = ifc.issue_qk;
            e.imm = ifc.issue_imm; e.pc = ifc.issue_pc; e.rob = ifc.issue_rob;
            resolve(ifc.issue_qj_busy, ifc.issue_qj, ifc.issue_vj, e.qjb, e.vj);
            resolve(ifc.issue_qk_busy, ifc.issue_qk, ifc.issue_vk, e.qkb, e.vk);
            m[f] = e;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Called at a negedge with inputs set: check rs_full, advance model, clock once.
    task automatic tick();
        check("rs_full", {31'd0, ifc.rs_full}, {31'd0, m_full()});
        model_edge();
        @(negedge clk);
        ifc.issue_sgn   = 1'b0;
        ifc.alu_cdb_sgn = 1'b0;
        ifc.lsb_cdb_sgn = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [3:0] qj,
                             input bit qjb, input logic [31:0] vk, input logic [3:0] qk,
                             input bit qkb, input logic [31:0] imm, input logic [31:0] pc,
                             input logic [3:0] rob);
        ifc.issue_sgn = 1'b1; ifc.issue_opcode = op;
        ifc.issue_vj = vj; ifc.issue_qj = qj; ifc.issue_qj_busy = qjb;
        ifc.issue_vk = vk; ifc.issue_qk = qk; ifc.issue_qk_busy = qkb;
        ifc.issue_imm = imm; ifc.issue_pc = pc; ifc.issue_rob = rob;
    endtask

    task automatic set_alu_cdb(input logic [3:0] t, input logic [31:0] r);
        ifc.alu_cdb_sgn = 1'b1; ifc.alu_cdb_rob = t; ifc.alu_cdb_result = r;
    endtask

    task automatic set_lsb_cdb(input logic [3:0] t, input logic [31:0] r);
        ifc.lsb_cdb_sgn = 1'b1; ifc.lsb_cdb_rob = t; ifc.lsb_cdb_result = r;
    endtask

    task automatic drain();
        for (int r = 0; r < 2; r++) begin
            for (int t = 0; t < 16; t++) begin
                set_alu_cdb(4'(t), 32'hD000_0000 + 32'(t));
                tick();
            end
        end
        idle(20);
    endtask

    // Monitor: every live edge that shows alu_sgn=1 must match the oldest prediction.
    initial begin : monitor
        exp_t e;
        bit   live;
        forever begin
            @(posedge clk);
            edge_cnt++;
            live = rdy && !rst;
            #1;
            if (live && ifc.alu_sgn) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dispatch_unexpected: got rob %0d at edge %0d, required none",
                             ifc.alu_rob, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_no != edge_cnt || ifc.alu_opcode !== e.op || ifc.alu_lhs !== e.lhs ||
                        ifc.alu_rhs !== e.rhs || ifc.alu_imm !== e.imm || ifc.alu_pc !== e.pc ||
                        ifc.alu_rob !== e.rob) begin
                        n_fail++;
                        $display("FAIL dispatch: got edge %0d op %h lhs %h rhs %h imm %h pc %h rob %0d required edge %0d op %h lhs %h rhs %h imm %h pc %h rob %0d",
                                 edge_cnt, ifc.alu_opcode, ifc.alu_lhs, ifc.alu_rhs, ifc.alu_imm,
                                 ifc.alu_pc, ifc.alu_rob, e.edge_no, e.op, e.lhs, e.rhs, e.imm,
                                 e.pc, e.rob);
                    end else begin
                        $display("dispatch edge %0d rob %0d op %h lhs %h rhs %h ok",
                                 edge_cnt, e.rob, e.op, e.lhs, e.rhs);
                    end
                end
            end else if (live && exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
                n_cmp++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL dispatch_missing: got alu_sgn 0 at edge %0d, required rob %0d",
                         edge_cnt, e.rob);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        ifc.issue_sgn = 1'b0; ifc.issue_opcode = '0; ifc.issue_vj = '0; ifc.issue_qj = '0;
        ifc.issue_qj_busy = 1'b0; ifc.issue_vk = '0; ifc.issue_qk = '0; ifc.issue_qk_busy = 1'b0;
        ifc.issue_imm = '0; ifc.issue_pc = '0; ifc.issue_rob = '0;
        ifc.alu_cdb_sgn = 1'b0; ifc.alu_cdb_rob = '0; ifc.alu_cdb_result = '0;
        ifc.lsb_cdb_sgn = 1'b0; ifc.lsb_cdb_rob = '0; ifc.lsb_cdb_result = '0;
        model_edge();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_alu_sgn", {31'd0, ifc.alu_sgn}, 32'd0);
        check("reset_rs_full", {31'd0, ifc.rs_full}, 32'd0);
        check("reset_alu_lhs", ifc.alu_lhs, 32'd0);
        check("reset_alu_rob", {28'd0, ifc.alu_rob}, 32'd0);

        // ADDI with both operands ready
        set_issue(6'h13, 32'd5, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd3, 32'h100, 4'd2);
        idle(4);

        // ADD waiting on tag 7, woken by the ALU CDB two cycles later
        set_issue(6'h01, 32'd0, 4'd7, 1'b1, 32'd9, 4'd0, 1'b0, 32'd0, 32'h104, 4'd8);
        idle(2);
        set_alu_cdb(4'd7, 32'h10);
        idle(4);

        // Issue-time forwarding from the LSB CDB
        set_issue(6'h02, 32'd1, 4'd0, 1'b0, 32'd0, 4'd3, 1'b1, 32'd0, 32'h108, 4'd4);
        set_lsb_cdb(4'd3, 32'hAB);
        idle(4);

        // Fill all 16 slots, drop a 17th, wake 4 and 9 together
        for (int i = 0; i < 16; i++) begin
            set_issue(6'(i + 8), 32'd0, 4'(i), 1'b1, 32'h500 + 32'(i), 4'd0, 1'b0,
                      32'(i), 32'h2000 + 32'(4 * i), 4'(i));
            tick();
        end
        set_issue(6'h3F, 32'hDEAD, 4'd0, 1'b1, 32'hBEEF, 4'd0, 1'b0, 32'hF00, 32'hFFF0, 4'd15);
        tick();
        set_alu_cdb(4'd4, 32'h44);
        set_lsb_cdb(4'd9, 32'h99);
        idle(3);
        drain();

        // Clear with five waiting entries and one dispatch pending
        for (int i = 0; i < 5; i++) begin
            set_issue(6'h05, 32'd0, 4'(10 + i), 1'b1, 32'd7, 4'd0, 1'b0, 32'd0, 32'h3000, 4'(i));
            tick();
        end
        set_issue(6'h06, 32'h77, 4'd0, 1'b0, 32'h66, 4'd0, 1'b0, 32'd1, 32'h3100, 4'd6);
        tick();
        clear = 1'b1;
        tick();
        check("clear_alu_sgn", {31'd0, ifc.alu_sgn}, 32'd0);
        check("clear_alu_lhs", ifc.alu_lhs, 32'd0);
        check("clear_alu_opcode", {26'd0, ifc.alu_opcode}, 32'd0);
        check("clear_alu_pc", ifc.alu_pc, 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_alu_cdb(4'(10 + i), 32'h1234);
            tick();
        end
        idle(3);

        // rdy low for 3 cycles with a ready entry and a CDB broadcast present
        set_issue(6'h07, 32'd0, 4'd5, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 32'h4000, 4'd10);
        tick();
        set_issue(6'h08, 32'h21, 4'd0, 1'b0, 32'h22, 4'd0, 1'b0, 32'd3, 32'h4004, 4'd11);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_alu_cdb(4'd5, 32'h55);
            set_issue(6'h09, 32'h31, 4'd0, 1'b0, 32'h32, 4'd0, 1'b0, 32'd0, 32'h4008, 4'd12);
            tick();
        end
        rdy = 1'b1;
        idle(3);
        set_alu_cdb(4'd5, 32'h56);
        idle(4);

        // Randomised traffic
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(99) < 55)
                set_issue(6'($urandom), $urandom, 4'($urandom), 1'($urandom),
                          $urandom, 4'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
            if ($urandom_range(99) < 45) set_alu_cdb(4'($urandom), $urandom);
            if ($urandom_range(99) < 35) set_lsb_cdb(4'($urandom), $urandom);
            rdy = ($urandom_range(99) >= 10);
            if ($urandom_range(199) < 3) clear = 1'b1;
            tick();
        end
        rdy = 1'b1;
        drain();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_dispatches: got %0d outstanding, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end
endmodule
